// File: rtl/axi_pkg.sv
// Shared encodings and FSM state types for the AXI RAM responder.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DATA} r_state_t;

endpackage

// File: rtl/axi_ram_responder_if.sv
// AXI4 bus bundle (no lock/cache/prot/qos/region/user) between a master and the RAM responder.
// Handshake: a beat transfers on a rising edge where valid and ready are both 1; once valid is
// raised the sender holds it and its payload unchanged until that edge; ready may change freely.
interface axi_ram_responder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8
);
   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awvalid;
   logic                  awready;

   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;

   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input bid, bresp, bvalid, output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
      input rid, rdata, rresp, rlast, rvalid, output rready
   );

   modport slave (
      input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
      input wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready,
      input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready
   );
endinterface

// File: rtl/axi_ram_sdp.sv
// Simple dual-port RAM: byte-enabled write port, registered read port (read-first on collision).
module axi_ram_sdp #(
   parameter int DATA_WIDTH  = 32,
   parameter int STRB_WIDTH  = DATA_WIDTH / 8,
   parameter int INDEX_WIDTH = 14
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [STRB_WIDTH-1:0]  wstrb,
   input  logic [INDEX_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]  wdata,
   input  logic                   re,
   input  logic [INDEX_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0]  rdata
);
   logic [DATA_WIDTH-1:0] mem [2**INDEX_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 slave that terminates bursts in block RAM; independent write and read FSMs share one SDP RAM.
module axi_ram_responder
   import axi_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8
) (
   input  logic                s_axi_clk,
   input  logic                s_axi_rst,
   axi_ram_responder_if.slave  s_axi,
   output w_state_t            w_state,
   output r_state_t            r_state
);
   localparam int OFFSET_WIDTH = $clog2(STRB_WIDTH);
   localparam int INDEX_WIDTH  = ADDR_WIDTH - OFFSET_WIDTH;

   logic [ID_WIDTH-1:0]    w_id, bid_q;
   logic [INDEX_WIDTH-1:0] w_addr;
   logic [7:0]             w_len, w_cnt;
   logic [1:0]             w_burst, bresp_q;
   logic                   w_err, awready_q, wready_q, bvalid_q;
   logic                   w_beat, w_final;

   logic [ID_WIDTH-1:0]    r_id, rid_q;
   logic [INDEX_WIDTH-1:0] r_addr;
   logic [7:0]             r_len, r_cnt;
   logic [1:0]             r_burst;
   logic                   arready_q, rvalid_q, rlast_q;
   logic [DATA_WIDTH-1:0]  ram_q;

   // Size fields and sub-word address bits have no effect: every beat is full width.
   logic unused_ok;
   assign unused_ok = ^{s_axi.awsize, s_axi.arsize, s_axi.awaddr, s_axi.araddr};

   assign w_beat  = s_axi.wvalid && wready_q;
   assign w_final = (w_cnt == w_len);

   always_ff @(posedge s_axi_clk) begin
      if (s_axi_rst) begin
         w_state   <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         bid_q     <= '0;
         w_id      <= '0;
         w_addr    <= '0;
         w_len     <= '0;
         w_cnt     <= '0;
         w_burst   <= BURST_INCR;
         w_err     <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               awready_q <= 1'b1;
               if (s_axi.awvalid && awready_q) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  w_id      <= s_axi.awid;
                  w_addr    <= s_axi.awaddr[ADDR_WIDTH-1:OFFSET_WIDTH];
                  w_len     <= s_axi.awlen;
                  w_burst   <= s_axi.awburst;
                  w_cnt     <= '0;
                  w_err     <= 1'b0;
                  w_state   <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_beat) begin
                  // WRAP is handled as INCR; only FIXED holds the address.
                  if (w_burst != BURST_FIXED) w_addr <= w_addr + INDEX_WIDTH'(1);
                  if (s_axi.wlast != w_final) w_err <= 1'b1;
                  if (w_final) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bid_q    <= w_id;
                     bresp_q  <= (w_err || !s_axi.wlast) ? RESP_SLVERR : RESP_OKAY;
                     w_state  <= W_RESP;
                  end else begin
                     w_cnt <= w_cnt + 8'd1;
                  end
               end
            end
            W_RESP: begin
               if (s_axi.bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  w_state   <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge s_axi_clk) begin
      if (s_axi_rst) begin
         r_state   <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         r_id      <= '0;
         r_addr    <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_burst   <= BURST_INCR;
      end else begin
         case (r_state)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (s_axi.arvalid && arready_q) begin
                  arready_q <= 1'b0;
                  r_id      <= s_axi.arid;
                  r_addr    <= s_axi.araddr[ADDR_WIDTH-1:OFFSET_WIDTH];
                  r_len     <= s_axi.arlen;
                  r_burst   <= s_axi.arburst;
                  r_cnt     <= '0;
                  r_state   <= R_ISSUE;
               end
            end
            R_ISSUE: begin
               rvalid_q <= 1'b1;
               rlast_q  <= (r_cnt == r_len);
               rid_q    <= r_id;
               r_state  <= R_DATA;
            end
            R_DATA: begin
               if (s_axi.rready) begin
                  rvalid_q <= 1'b0;
                  if (rlast_q) begin
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     r_state   <= R_IDLE;
                  end else begin
                     if (r_burst != BURST_FIXED) r_addr <= r_addr + INDEX_WIDTH'(1);
                     r_cnt   <= r_cnt + 8'd1;
                     r_state <= R_ISSUE;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   axi_ram_sdp #(
      .DATA_WIDTH  (DATA_WIDTH),
      .STRB_WIDTH  (STRB_WIDTH),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_ram (
      .clk   (s_axi_clk),
      .we    (w_beat),
      .wstrb (s_axi.wstrb),
      .waddr (w_addr),
      .wdata (s_axi.wdata),
      .re    (r_state == R_ISSUE),
      .raddr (r_addr),
      .rdata (ram_q)
   );

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bid     = bid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rlast   = rlast_q;
   assign s_axi.rid     = rid_q;
   assign s_axi.rresp   = RESP_OKAY;
   // RAM output is masked so rdata reads 0 whenever no beat is offered, including in reset.
   assign s_axi.rdata   = ram_q & {DATA_WIDTH{rvalid_q}};
endmodule
